// File: rtl/maxpool_column_2x2.sv
// 2x2 / stride-2 max-pool over a stream of columns. A column pair is reduced
// row-pair-wise in per-lane slices; a small FSM tracks which column of a pair is next.

module maxpool_lane #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] top,
  input  logic [DATA_WIDTH-1:0] bot,
  input  logic                  ld_hold,
  input  logic                  ld_out,
  output logic [DATA_WIDTH-1:0] q
);
  logic [DATA_WIDTH-1:0] top_c, bot_c, v, hold;

  // a set MSB means the upstream ReLU guarantee was broken; treat as zero
  assign top_c = top[DATA_WIDTH-1] ? '0 : top;
  assign bot_c = bot[DATA_WIDTH-1] ? '0 : bot;
  assign v     = (top_c >= bot_c) ? top_c : bot_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      hold <= '0;
      q    <= '0;
    end else begin
      if (ld_hold) hold <= v;
      if (ld_out)  q    <= (hold >= v) ? hold : v;
    end
  end
endmodule

module maxpool_column_2x2 #(
  parameter int COLUMN_SIZE = 24,
  parameter int DATA_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  col_valid_i,
  output logic                  col_ready_o,
  input  logic [DATA_WIDTH-1:0] col_data_i [COLUMN_SIZE],
  input  logic                  col_last_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] out_data_o [COLUMN_SIZE/2],
  output logic                  out_last_o
);
  localparam int NUM_LANES = COLUMN_SIZE / 2;

  if (COLUMN_SIZE % 2 != 0) begin : g_bad_size
    $error("maxpool_column_2x2: COLUMN_SIZE must be even");
  end

  typedef enum logic {EVEN, ODD} state_t;
  state_t state_q, state_d;

  logic col_acc, out_take, ld_hold, ld_out;

  assign col_acc  = col_valid_i && col_ready_o;
  assign out_take = out_valid_o && out_ready_i;

  always_comb begin
    state_d     = state_q;
    col_ready_o = 1'b1;
    ld_hold     = 1'b0;
    ld_out      = 1'b0;
    case (state_q)
      EVEN: begin
        // only writes hold, so back-pressure on the output does not stall it
        if (col_valid_i) begin
          ld_hold = 1'b1;
          if (!col_last_i) state_d = ODD;
        end
      end
      ODD: begin
        col_ready_o = !out_valid_o || out_ready_i;
        if (col_acc) begin
          ld_out  = 1'b1;
          state_d = EVEN;
        end
      end
      default: state_d = EVEN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EVEN;
      out_valid_o <= 1'b0;
      out_last_o  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (ld_out) begin
        out_valid_o <= 1'b1;
        out_last_o  <= col_last_i;
      end else if (out_take) begin
        out_valid_o <= 1'b0;
      end
    end
  end

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    maxpool_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
      .clk     (clk),
      .rst     (rst),
      .top     (col_data_i[2*k]),
      .bot     (col_data_i[2*k+1]),
      .ld_hold (ld_hold),
      .ld_out  (ld_out),
      .q       (out_data_o[k])
    );
  end
endmodule

// File: doc/maxpool_column_2x2.md
# maxpool_column_2x2

Streaming 2×2 / stride-2 max-pool stage that consumes the rectified feature-map columns produced by the ReLU column stage. It receives one column of `COLUMN_SIZE` values per handshake and emits one pooled column of `COLUMN_SIZE/2` values for every two input columns. Every output element is the maximum of a 2×2 window. The block sits between the ReLU column stage and the next layer's column buffer, with valid/ready flow control on both sides.

## Interface
- `COLUMN_SIZE`, 24: elements per input column. Must be even; an odd value is an elaboration error (`$error`).
- `DATA_WIDTH`, 16: bits per element.
- `clk` input 1: sole clock. All state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `col_valid_i` input 1: input column present.
- `col_ready_o` output 1: block accepts the input column this cycle.
- `col_data_i` input `[DATA_WIDTH-1:0] [COLUMN_SIZE]`: input column; element 0 is the top row.
- `col_last_i` input 1: this column is the last column of the feature map.
- `out_valid_o` output 1: pooled column present.
- `out_ready_i` input 1: downstream accepts the pooled column.
- `out_data_o` output `[DATA_WIDTH-1:0] [COLUMN_SIZE/2]`: pooled column, registered.
- `out_last_o` output 1: pooled column is the last one of the feature map.

## Operation
- **Input acceptance.** An input column is accepted when `col_valid_i && col_ready_o`. An output column is taken when `out_valid_o && out_ready_i`.
- **Comparison.** Compare elements as unsigned `DATA_WIDTH`-bit values. This is correct for non-negative fp16 and for non-negative fixed point.
- **Clamping.** An element with the MSB set violates the ReLU guarantee. Treat it as 0 before any comparison.
- **Vertical max.** `v[k] = max(col[2k], col[2k+1])` for `k = 0 .. COLUMN_SIZE/2-1`. Computed combinationally.
- **FSM, 2 states:**
  - **EVEN** (reset state): waiting for the first column of a pair.
    - `col_ready_o = 1`.
    - On accept: `hold[k] <= v[k]`.
    - If `col_last_i = 0`: go to ODD.
    - If `col_last_i = 1` (odd map width): discard the lone column, produce no output, stay in EVEN.
  - **ODD**: holding the first column of a pair.
    - `col_ready_o = !out_valid_o || out_ready_i`.
    - On accept: `out_data_o[k] <= max(hold[k], v[k])`, `out_last_o <= col_last_i`, `out_valid_o <= 1`, go to EVEN.
- **Output register.** While `out_valid_o = 1`, the output register holds its value until taken. On a take with no new load in the same cycle, `out_valid_o <= 0`.
- **Simultaneous take and load.** A take and a new ODD load may occur in the same cycle. The new value loads and `out_valid_o` stays 1.
- **EVEN accepts under back-pressure.** An EVEN-state accept only writes `hold`, so it proceeds even while the output is stalled.
- **Ties.** Equal values give that value. No source tracking.
- **Reset values:** state = EVEN, `out_valid_o = 0`, `out_last_o = 0`, `out_data_o = 0`, `hold = 0`, `col_ready_o = 1`.
- **Reset mid-operation.** Any partially held pair and any untaken output are dropped. The next accepted column is treated as a pair's first column.
- **Input stability.** `col_data_i` and `col_last_i` are sampled only on an accept. Values while `col_valid_i = 0` are ignored.

## Timing
- **Latency.** `out_valid_o` rises the cycle after the second column of a pair is accepted.
- **Throughput.** One input column per cycle with `out_ready_i` held at 1, giving one output per 2 cycles.
- **Combinational paths.**
  - `col_ready_o` depends combinationally on `out_ready_i` (ODD only) and on registered state. No other combinational input-to-output path.
  - `out_data_o`, `out_valid_o` and `out_last_o` are registered.
- **Downstream rule.** Downstream must not require `out_ready_i` to depend on `out_valid_o` combinationally through this block.
- **Upstream rule.** Once `col_valid_i` is asserted, upstream holds the column until accepted. The block does not rely on this for correctness.

## Test plan
- **Basic pooling.** After reset, send column A with `col[i] = i` and column B with `col[i] = 100 - i`, back-to-back, `out_ready_i = 1`. Required: one output, one cycle after B; `out[k] = 100 - 2k` (max of 2k, 2k+1, 100-2k, 99-2k); `out_last_o = 0`.
- **Back-pressure.**
  - `out_ready_i = 0` with a pending output: a third column is accepted (EVEN).
  - A fourth column sees `col_ready_o = 0`. `out_data_o` stays stable until `out_ready_i = 1`.
  - The fourth column is then accepted in the same cycle as the take; next cycle `out_valid_o = 1` with the new pair.
- **Odd map width.** Send 3 columns with `col_last_i` on the third. Required: exactly 1 output, `out_last_o = 0`, state back to EVEN. A following 2-column frame with last on column 2 gives 1 output with `out_last_o = 1`.
- **Clamping.** Send columns with all elements 0x8001 except `col[5] = 0x3C00` in column B. Required: `out[2] = 0x3C00`; all other outputs 0x0000.
- **Reset mid-pair.** Accept one column, assert `rst` for 1 cycle, then send a 2-column pair of all 0x0007. Required: exactly one output of all 0x0007; no output contains the pre-reset column's data.
- **Streaming.** Send 48 random non-negative columns at full rate with random `out_ready_i`. Required: 24 outputs matching a reference 2×2 max model, in order, with none lost or duplicated.
